// File: rtl/bnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_layer_sequencer
//  Description : Top-level inference controller for the binary MNIST network.
//                Drives the shared 3-bit stage bus decoded by every layer
//                block, steps through image load and the three layers on
//                each stage's done flag, and soft-clears the layers (whose
//                done flags are sticky) at the start of each inference.
//                A per-stage watchdog moves to ERROR when a stage hangs.
//                A latency accumulator and an inference counter report
//                run statistics.
//
//  Ports       :
//    clk            in   1      system clock, rising edge
//    rst            in   1      asynchronous active-high reset
//    start          in   1      begin an inference (honoured in IDLE only)
//    abort          in   1      cancel the inference / leave DONE or ERROR
//    load_done      in   1      image loader finished (level or pulse)
//    l1_done        in   1      layer one complete (sticky)
//    l2_done        in   1      layer two complete (sticky)
//    l3_done        in   1      layer three complete (sticky)
//    result_ack     in   1      consumer has read the classification
//    state          out  3      stage bus to all layers
//    layer_rst_n    out  1      active-low synchronous clear to the layers
//    busy           out  1      inference in progress
//    result_valid   out  1      classification available (DONE)
//    error          out  1      watchdog fired (ERROR)
//    last_latency   out  LAT_W  CLEAR-entry to DONE-entry cycles, last run
//    infer_count    out  CNT_W  completed inferences, wraps
//
//  Revision    : 1.0  initial release
// ============================================================================
module bnn_layer_sequencer #(
    parameter int TIMEOUT = 1023,
    parameter int LAT_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             load_done,
    input  logic             l1_done,
    input  logic             l2_done,
    input  logic             l3_done,
    input  logic             result_ack,
    output logic [2:0]       state,
    output logic             layer_rst_n,
    output logic             busy,
    output logic             result_valid,
    output logic             error,
    output logic [LAT_W-1:0] last_latency,
    output logic [CNT_W-1:0] infer_count
);

    // ------------------------------------------------------------------
    // Stage bus encoding, shared with every layer block
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_L1    = 3'b010;
    localparam logic [2:0] S_L2    = 3'b011;
    localparam logic [2:0] S_L3    = 3'b100;
    localparam logic [2:0] S_DONE  = 3'b101;
    localparam logic [2:0] S_ERROR = 3'b110;
    localparam logic [2:0] S_CLEAR = 3'b111;

    // The watchdog never has to hold more than TIMEOUT-1: on that value the
    // state always changes (done or ERROR), which clears it.
    localparam int               WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       state_q,        state_d;
    logic [WD_W-1:0]  wd_q,           wd_d;
    logic [LAT_W-1:0] acc_q,          acc_d;
    logic [LAT_W-1:0] last_lat_q,     last_lat_d;
    logic [CNT_W-1:0] infer_cnt_q,    infer_cnt_d;
    logic             layer_rst_n_q,  layer_rst_n_d;
    logic             busy_q,         busy_d;
    logic             result_valid_q, result_valid_d;
    logic             error_q,        error_d;

    // ------------------------------------------------------------------
    // Helper decodes of the current state
    // ------------------------------------------------------------------
    logic w_in_stage;     // LOAD or any LAYER state: watchdog is running
    logic w_in_run;       // CLEAR, LOAD or any LAYER state: latency counts
    logic w_done_cur;     // the done flag that belongs to the current stage
    logic w_wd_expired;   // last permitted cycle of the current stage

    always_comb begin
        w_in_stage = (state_q == S_LOAD) || (state_q == S_L1) ||
                     (state_q == S_L2)   || (state_q == S_L3);
        w_in_run   = w_in_stage || (state_q == S_CLEAR);

        // Only the current stage's flag is looked at, so stale flags left
        // high by other stages can never cause a skip.
        case (state_q)
            S_LOAD:  w_done_cur = load_done;
            S_L1:    w_done_cur = l1_done;
            S_L2:    w_done_cur = l2_done;
            S_L3:    w_done_cur = l3_done;
            default: w_done_cur = 1'b0;
        endcase

        w_wd_expired = w_in_stage && (wd_q == WD_LAST);
    end

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // abort wins a collision with start
                if (start && !abort) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_LOAD;
            end
            S_LOAD, S_L1, S_L2, S_L3: begin
                // abort beats done, done beats the watchdog on its last cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_done_cur) begin
                    case (state_q)
                        S_LOAD:  state_d = S_L1;
                        S_L1:    state_d = S_L2;
                        S_L2:    state_d = S_L3;
                        default: state_d = S_DONE;
                    endcase
                end else if (w_wd_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                if (abort || result_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                // only abort (or reset) leaves ERROR; start is ignored here
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output / datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        layer_rst_n_d  = (state_d != S_CLEAR);
        busy_d         = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                         (state_d == S_L1)    || (state_d == S_L2)   ||
                         (state_d == S_L3);
        result_valid_d = (state_d == S_DONE);
        error_d        = (state_d == S_ERROR);

        // Watchdog restarts on every transition and only runs in stages.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (w_in_stage) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end

        // Accumulator holds 1 during the CLEAR cycle and gains one per cycle
        // afterwards, so on DONE entry it equals the cycles spent since
        // CLEAR entry.
        if ((state_q == S_IDLE) && (state_d == S_CLEAR)) begin
            acc_d = LAT_W'(1);
        end else if (w_in_run && (acc_q != LAT_MAX)) begin
            acc_d = acc_q + LAT_W'(1);
        end else begin
            acc_d = acc_q;
        end

        // Statistics change only on a successful DONE entry; abort and
        // ERROR leave them untouched.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            last_lat_d  = acc_q;
            infer_cnt_d = infer_cnt_q + CNT_W'(1);
        end else begin
            last_lat_d  = last_lat_q;
            infer_cnt_d = infer_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q           <= '0;
            acc_q          <= '0;
            last_lat_q     <= '0;
            infer_cnt_q    <= '0;
            layer_rst_n_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wd_q           <= wd_d;
            acc_q          <= acc_d;
            last_lat_q     <= last_lat_d;
            infer_cnt_q    <= infer_cnt_d;
            layer_rst_n_q  <= layer_rst_n_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign state        = state_q;
    assign layer_rst_n  = layer_rst_n_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign last_latency = last_lat_q;
    assign infer_count  = infer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_layer_sequencer
//  Description : Scoreboard bench for bnn_layer_sequencer. Stimulus plans each
//                inference as a list of per-stage done delays; a reference
//                model turns the plan into the expected list of state
//                transitions (with stage durations, latency and counter
//                values) and queues it. A monitor pops one entry on every
//                observed state change. A behavioural layer environment raises
//                the done flags after the planned number of cycles and drops
//                them when the layers are cleared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bnn_layer_sequencer;

    localparam int TIMEOUT = 1023;
    localparam int LAT_W   = 16;
    localparam int CNT_W   = 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] L1    = 3'd2;
    localparam logic [2:0] L2    = 3'd3;
    localparam logic [2:0] L3    = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             load_done;
    logic             l1_done;
    logic             l2_done;
    logic             l3_done;
    logic             result_ack;
    logic [2:0]       state;
    logic             layer_rst_n;
    logic             busy;
    logic             result_valid;
    logic             error;
    logic [LAT_W-1:0] last_latency;
    logic [CNT_W-1:0] infer_count;

    bnn_layer_sequencer #(
        .TIMEOUT (TIMEOUT),
        .LAT_W   (LAT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .load_done    (load_done),
        .l1_done      (l1_done),
        .l2_done      (l2_done),
        .l3_done      (l3_done),
        .result_ack   (result_ack),
        .state        (state),
        .layer_rst_n  (layer_rst_n),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error),
        .last_latency (last_latency),
        .infer_count  (infer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] st;
        int         dur;   // cycles spent in the state being left, -1 = any
        int         lat;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   exp_lat = 0;
    int   exp_cnt = 0;
    int   plan_d[4];   // done delay (cycles into the stage) for LOAD..L3
    bit   stale3  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_st(input logic [2:0] s, input int dur);
        exp_t e;
        e.st  = s;
        e.dur = dur;
        e.lat = exp_lat;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
        int n = 0;
        while (state !== s && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, state %0d, expected %0d", name, state, s);
        end
    endtask

    // Reference model: each stage lasts its planned delay unless that exceeds
    // TIMEOUT cycles, in which case the stage ends in ERROR after TIMEOUT.
    task automatic model_run(output logic [2:0] fin);
        int total;
        expect_st(CLEAR, -1);
        expect_st(LOAD, 1);
        total = 1;
        fin   = DONE;
        for (int i = 0; i < 4; i++) begin
            if (plan_d[i] > TIMEOUT) begin
                expect_st(ERROR, TIMEOUT);
                fin = ERROR;
                return;
            end
            total += plan_d[i];
            if (i < 3) begin
                expect_st(3'(i + 2), plan_d[i]);
            end else begin
                exp_lat = (total > 65535) ? 65535 : total;
                exp_cnt = (exp_cnt + 1) % 256;
                expect_st(DONE, plan_d[3]);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input int d0, input int d1, input int d2, input int d3,
                          input bit st3, input bit abort_exit);
        logic [2:0] fin;
        plan_d[0] = d0;
        plan_d[1] = d1;
        plan_d[2] = d2;
        plan_d[3] = d3;
        stale3    = st3;
        model_run(fin);
        pulse_start();
        wait_state(fin, 6000, "reach_final");
        if (fin == DONE) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            expect_st(IDLE, -1);
            if (abort_exit) abort = 1'b1;
            else            result_ack = 1'b1;
            @(negedge clk);
            abort      = 1'b0;
            result_ack = 1'b0;
        end else begin
            chk("error_flag", error, 1);
            chk("error_busy", busy, 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            chk("error_ignores_start", state, ERROR);
            expect_st(IDLE, -1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        wait_state(IDLE, 20, "back_to_idle");
        chk("idle_error_clear", error, 0);
        stale3 = 1'b0;
    endtask

    task automatic do_abort_l2(input int k);
        plan_d[0] = 3;
        plan_d[1] = 10;
        plan_d[2] = 900;
        plan_d[3] = 5;
        expect_st(CLEAR, -1);
        expect_st(LOAD, 1);
        expect_st(L1, 3);
        expect_st(L2, 10);
        expect_st(IDLE, k + 1);
        pulse_start();
        wait_state(L2, 100, "abort_reach_l2");
        repeat (k) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_to_idle", state, IDLE);
        chk("abort_count_kept", infer_count, exp_cnt);
        chk("abort_latency_kept", last_latency, exp_lat);
        chk("abort_no_error", error, 0);
    endtask

    // Behavioural layer blocks: done rises on the planned cycle of its stage,
    // stays high until the layers are cleared.
    initial begin : env
        int         cnt;
        logic [2:0] prev;
        cnt       = 0;
        prev      = IDLE;
        load_done = 1'b0;
        l1_done   = 1'b0;
        l2_done   = 1'b0;
        l3_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (layer_rst_n !== 1'b1) begin
                l1_done = 1'b0;
                l2_done = 1'b0;
                l3_done = 1'b0;
            end
            if (state != LOAD) load_done = 1'b0;
            if (state != prev) cnt = 0;
            prev = state;
            if (state inside {LOAD, L1, L2, L3}) begin
                cnt++;
                if (cnt == plan_d[int'(state) - 1]) begin
                    case (state)
                        LOAD:    load_done = 1'b1;
                        L1:      l1_done   = 1'b1;
                        L2:      l2_done   = 1'b1;
                        default: l3_done   = 1'b1;
                    endcase
                end
            end
            if (stale3 && state == L1) l3_done = 1'b1;
        end
    end

    // Monitor: every state change is matched against the next queued entry.
    initial begin : mon
        logic [2:0] prev;
        int         dur;
        exp_t       e;
        prev = IDLE;
        dur  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = state;
                dur  = 0;
            end else if (state !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_transition: got state %0d, expected to stay in %0d", state, prev);
                end else begin
                    e = exp_q.pop_front();
                    chk("state", state, e.st);
                    if (e.dur >= 0) chk("stage_cycles", dur, e.dur);
                    chk("layer_rst_n", layer_rst_n, e.st != CLEAR);
                    chk("busy", busy, e.st inside {CLEAR, LOAD, L1, L2, L3});
                    chk("result_valid", result_valid, e.st == DONE);
                    chk("error", error, e.st == ERROR);
                    chk("last_latency", last_latency, e.lat);
                    chk("infer_count", infer_count, e.cnt);
                end
                prev = state;
                dur  = 1;
            end else begin
                dur++;
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, state, IDLE);
        chk({tag, "_layer_rst_n"}, layer_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_last_latency"}, last_latency, 0);
        chk({tag, "_infer_count"}, infer_count, 0);
    endtask

    initial begin : stim
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        result_ack = 1'b0;
        plan_d     = '{1, 1, 1, 1};
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // nominal run: latency 1 + 5 + 200 + 785 + 100
        do_run(5, 200, 785, 100, 1'b0, 1'b0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("collision_stays_idle", state, IDLE);

        // watchdog in LAYER_2, then the boundary where done wins
        do_run(3, 4, 2000, 5, 1'b0, 1'b0);
        do_run(2, 3, TIMEOUT, 4, 1'b0, 1'b1);

        // stale l3_done held through LAYER_1 and LAYER_2
        do_run(4, 6, 8, 1, 1'b1, 1'b0);

        do_abort_l2($urandom_range(1, 40));

        // randomized runs, occasionally straddling the watchdog limit
        for (int r = 0; r < 16; r++) begin
            int d[4];
            bit st3;
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(1, 30);
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 3)] = $urandom_range(1015, 1030);
            st3 = ($urandom_range(0, 3) == 0);
            if (st3) d[3] = 1;
            do_run(d[0], d[1], d[2], d[3], st3, 1'($urandom_range(0, 1)));
        end

        // asynchronous reset between clock edges mid-LAYER_1
        plan_d[0] = 2;
        plan_d[1] = 500;
        plan_d[2] = 5;
        plan_d[3] = 5;
        expect_st(CLEAR, -1);
        expect_st(LOAD, 1);
        expect_st(L1, 2);
        pulse_start();
        wait_state(L1, 50, "rst_reach_l1");
        repeat (3) @(negedge clk);
        #2;
        exp_lat = 0;
        exp_cnt = 0;
        expect_st(IDLE, -1);
        rst = 1'b1;
        #1;
        chk_reset_values("async_reset");
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 256 completed runs wrap the inference counter to 0
        for (int r = 0; r < 256; r++) begin
            do_run($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)));
        end
        chk("wrap_count", infer_count, exp_cnt);
        chk("wrap_is_zero", infer_count, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : guard
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
